// File: rtl/divider_arbiter.sv
// divider_arbiter
//
// Shares one external divider between two requesters. Requests are arbitrated
// round-robin, the winner's operands are latched, and the divider's go/done
// handshake is sequenced. Every accepted request gets exactly one response on
// a common tagged response bus. Divide-by-zero is answered without using the
// divider. A watchdog aborts a request whose divider never raises done.
//
// Parameters
//   WIDTH    operand/result width, must match the divider
//   TIMEOUT  max cycles spent in WAIT before aborting (2..255)
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   req0/1, dividend0/1,     request valid and operands from requester 0/1
//   divisor0/1
//   gnt0/1                   one-cycle accept pulse per requester
//   rsp_valid, rsp_id,       response strobe, owner id, results and flags
//   rsp_quotient,
//   rsp_remainder,
//   rsp_error, rsp_timeout
//   div_go, div_dividend,    divider start pulse and latched operands
//   div_divisor
//   div_done, div_error,     divider result handshake and data
//   div_quotient,
//   div_remainder
//   busy, cs                 activity flag and current state encoding
module divider_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] dividend0,
  input  logic [WIDTH-1:0] divisor0,
  input  logic             req1,
  input  logic [WIDTH-1:0] dividend1,
  input  logic [WIDTH-1:0] divisor1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [WIDTH-1:0] rsp_remainder,
  output logic             rsp_error,
  output logic             rsp_timeout,
  output logic             div_go,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_done,
  input  logic             div_error,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             busy,
  output logic [1:0]       cs
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Last watchdog count before the abort fires; the counter starts at 0 on
  // the first WAIT cycle, so the abort lands after exactly TIMEOUT WAIT cycles.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t           state;
  logic             last_grant;
  logic             owner;
  logic [7:0]       wdog;

  logic             pick;
  logic [WIDTH-1:0] pick_dividend;
  logic [WIDTH-1:0] pick_divisor;

  // Round-robin winner: a lone requester always wins; on a tie the requester
  // that did not win last time goes first. With no request, pick is unused.
  always_comb begin
    pick = req1;
    if (req0 && req1) begin
      pick = ~last_grant;
    end
    pick_dividend = pick ? dividend1 : dividend0;
    pick_divisor  = pick ? divisor1  : divisor0;
  end

  assign cs = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      wdog          <= '0;
      gnt0          <= 1'b0;
      gnt1          <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_error     <= 1'b0;
      rsp_timeout   <= 1'b0;
      div_go        <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      busy          <= 1'b0;
    end else begin
      // Strobes are single-cycle; they are re-raised only by a transition.
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      div_go    <= 1'b0;
      rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (req0 || req1) begin
            last_grant   <= pick;
            owner        <= pick;
            gnt0         <= ~pick;
            gnt1         <= pick;
            div_dividend <= pick_dividend;
            div_divisor  <= pick_divisor;
            busy         <= 1'b1;
            if (pick_divisor == '0) begin
              // Divide-by-zero is answered directly; the divider is never started.
              state         <= RESP;
              rsp_valid     <= 1'b1;
              rsp_id        <= pick;
              rsp_quotient  <= '0;
              rsp_remainder <= '0;
              rsp_error     <= 1'b1;
              rsp_timeout   <= 1'b0;
            end else begin
              state  <= ISSUE;
              div_go <= 1'b1;
            end
          end
        end

        ISSUE: begin
          // div_done is deliberately ignored here: the divider has only just
          // seen go and any done now cannot belong to this request.
          state <= WAIT;
          wdog  <= '0;
        end

        WAIT: begin
          // done is tested first so a result arriving on the last watchdog
          // count is still delivered rather than reported as a timeout.
          if (div_done) begin
            state         <= RESP;
            rsp_valid     <= 1'b1;
            rsp_id        <= owner;
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_error     <= div_error;
            rsp_timeout   <= 1'b0;
          end else if (wdog == WDOG_LAST) begin
            state         <= RESP;
            rsp_valid     <= 1'b1;
            rsp_id        <= owner;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_error     <= 1'b1;
            rsp_timeout   <= 1'b1;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end

        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Testbench for divider_arbiter: two requester processes, a behavioural
// divider with programmable latency, and a scoreboard of expected grants and
// responses filled when stimulus is applied and drained by a monitor.
module tb_divider_arbiter;

  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0 = 1'b0;
  logic             req1 = 1'b0;
  logic [WIDTH-1:0] dividend0 = '0;
  logic [WIDTH-1:0] divisor0 = '0;
  logic [WIDTH-1:0] dividend1 = '0;
  logic [WIDTH-1:0] divisor1 = '0;
  logic             gnt0, gnt1, rsp_valid, rsp_id, rsp_error, rsp_timeout;
  logic [WIDTH-1:0] rsp_quotient, rsp_remainder;
  logic             div_go;
  logic [WIDTH-1:0] div_dividend, div_divisor;
  logic             div_done = 1'b0;
  logic             div_error = 1'b0;
  logic [WIDTH-1:0] div_quotient = '0;
  logic [WIDTH-1:0] div_remainder = '0;
  logic             busy;
  logic [1:0]       cs;

  divider_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .dividend0(dividend0), .divisor0(divisor0),
    .req1(req1), .dividend1(dividend1), .divisor1(divisor1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .div_go(div_go), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_error(div_error),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .busy(busy), .cs(cs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             err;
    logic             to;
  } rsp_t;

  op_t  pend0[$];
  op_t  pend1[$];
  rsp_t exp0[$];
  rsp_t exp1[$];
  int   expGnt[$];
  int   inflight[$];

  int   nChecks = 0;
  int   nFail = 0;
  int   cyc = 0;
  int   gntCyc = -1;
  int   goCyc = -1;
  int   rspCyc = -1;
  int   goCount = 0;
  int   divLat = 5;
  logic divErr = 1'b0;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Queue one request on a port and the response it must produce. Callers
  // apply requests in the grant order that round-robin arbitration requires.
  task automatic applyStimulus(input int port, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op_t  op;
    rsp_t e;
    op.a = a;
    op.b = b;
    if (b == '0) begin
      e.q = '0; e.r = '0; e.err = 1'b1; e.to = 1'b0;
    end else if (divLat < 1 || divLat > TIMEOUT) begin
      e.q = '0; e.r = '0; e.err = 1'b1; e.to = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.err = divErr; e.to = 1'b0;
    end
    expGnt.push_back(port);
    if (port == 0) begin
      pend0.push_back(op);
      exp0.push_back(e);
    end else begin
      pend1.push_back(op);
      exp1.push_back(e);
    end
  endtask

  function automatic logic [31:0] allOutputs();
    return {6'd0, gnt0, gnt1, rsp_valid, rsp_id, rsp_quotient, rsp_remainder,
            rsp_error, rsp_timeout, div_go, div_dividend, div_divisor, busy, cs};
  endfunction

  function automatic bit settled();
    return pend0.size() == 0 && pend1.size() == 0 && expGnt.size() == 0 &&
           inflight.size() == 0 && busy == 1'b0;
  endfunction

  // Returns on a negedge in IDLE once all queued work has completed.
  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!settled() && n < maxCycles);
    checkOutput("drainInTime", 32'(settled()), 32'd1);
  endtask

  // Cycle counter: value during a cycle is the number of rising edges so far.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requesters: hold req with stable operands until gnt, then move on.
  initial forever begin
    @(negedge clk);
    #1;
    if (gnt0 && pend0.size() > 0) void'(pend0.pop_front());
    if (gnt1 && pend1.size() > 0) void'(pend1.pop_front());
    if (pend0.size() > 0) begin
      req0 = 1'b1; dividend0 = pend0[0].a; divisor0 = pend0[0].b;
    end else begin
      req0 = 1'b0;
    end
    if (pend1.size() > 0) begin
      req1 = 1'b1; dividend1 = pend1[0].a; divisor1 = pend1[0].b;
    end else begin
      req1 = 1'b0;
    end
  end

  // Behavioural divider: done rises divLat cycles after the go cycle;
  // divLat < 1 means done never rises.
  initial begin
    int               cnt;
    bit               run;
    logic [WIDTH-1:0] opA, opB;
    run = 0;
    cnt = 0;
    opA = '0;
    opB = '0;
    forever begin
      @(negedge clk);
      div_done = 1'b0;
      if (!rst) begin
        run = 0;
      end else if (div_go) begin
        run = (divLat >= 1);
        cnt = divLat;
        opA = div_dividend;
        opB = div_divisor;
      end else if (run) begin
        cnt--;
        if (cnt == 0) begin
          run = 0;
          div_done = 1'b1;
          div_quotient  = (opB == '0) ? '0 : opA / opB;
          div_remainder = (opB == '0) ? '0 : opA % opB;
          div_error = divErr;
        end
      end
    end
  end

  // Monitor: match grants and responses against the scoreboard.
  initial forever begin
    int   e;
    rsp_t x;
    @(posedge clk);
    #1;
    if (rst) begin
      if (div_go) begin
        goCyc = cyc;
        goCount++;
      end
      if (gnt0 || gnt1) begin
        gntCyc = cyc;
        checkOutput("gntOneHot", 32'(gnt0 && gnt1), 32'd0);
        if (expGnt.size() == 0) begin
          checkOutput("gntUnexpected", 32'd1, 32'd0);
        end else begin
          e = expGnt.pop_front();
          checkOutput("gntId", 32'(gnt1), 32'(e));
          inflight.push_back(e);
        end
      end
      if (rsp_valid) begin
        rspCyc = cyc;
        if (inflight.size() == 0) begin
          checkOutput("rspUnexpected", 32'd1, 32'd0);
        end else begin
          e = inflight.pop_front();
          checkOutput("rspId", 32'(rsp_id), 32'(e));
          if ((e == 0 && exp0.size() == 0) || (e == 1 && exp1.size() == 0)) begin
            checkOutput("rspNoExpect", 32'd1, 32'd0);
          end else begin
            x = (e == 0) ? exp0.pop_front() : exp1.pop_front();
            checkOutput("rspQuotient", 32'(rsp_quotient), 32'(x.q));
            checkOutput("rspRemainder", 32'(rsp_remainder), 32'(x.r));
            checkOutput("rspError", 32'(rsp_error), 32'(x.err));
            checkOutput("rspTimeout", 32'(rsp_timeout), 32'(x.to));
          end
        end
      end
    end
  end

  // Global bound so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL globalTimeout: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail + 1);
    $fatal(1, "[TB] global time limit reached");
  end

  initial begin
    int t0;
    int goBefore;

    // Reset state
    #2 rst = 1'b0;
    #10;
    checkOutput("resetOutputs", allOutputs(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single request 13/4, done 5 cycles after go
    divLat = 5;
    t0 = cyc;
    applyStimulus(0, 4'd13, 4'd4);
    waitDrain(40);
    checkOutput("singleGntCycle", 32'(gntCyc - t0), 32'd1);
    checkOutput("singleGoCycle", 32'(goCyc - t0), 32'd1);
    checkOutput("singleRspCycle", 32'(rspCyc - t0), 32'd7);

    // Tie: last winner was 0, but both raised together after a 0-grant; use
    // a fresh tie where 1 last won so 0 goes first: push a lone req1 first.
    applyStimulus(1, 4'd3, 4'd1);
    waitDrain(40);
    applyStimulus(0, 4'd9, 4'd2);
    applyStimulus(1, 4'd14, 4'd3);
    waitDrain(60);

    // Round-robin fairness: both held for six transactions
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 4'(i + 5), 4'(i + 1));
      applyStimulus(1, 4'(15 - i), 4'(i + 2));
    end
    waitDrain(150);

    // Divide-by-zero: answered in the grant cycle, divider never started
    goBefore = goCount;
    t0 = cyc;
    applyStimulus(1, 4'd7, 4'd0);
    waitDrain(20);
    checkOutput("dbzGntCycle", 32'(gntCyc - t0), 32'd1);
    checkOutput("dbzRspCycle", 32'(rspCyc - t0), 32'd1);
    checkOutput("dbzNoGo", 32'(goCount), 32'(goBefore));

    // Divider-reported error passes through
    divErr = 1'b1;
    divLat = 2;
    applyStimulus(0, 4'd6, 4'd3);
    waitDrain(30);
    divErr = 1'b0;

    // done on the final watchdog count wins
    divLat = TIMEOUT;
    t0 = cyc;
    applyStimulus(0, 4'd15, 4'd2);
    waitDrain(40);
    checkOutput("doneAtLimitRspCycle", 32'(rspCyc - t0), 32'(TIMEOUT + 2));

    // done one cycle too late is a timeout
    divLat = TIMEOUT + 1;
    applyStimulus(1, 4'd10, 4'd3);
    waitDrain(40);

    // done never rises: timeout, then a normal request
    divLat = -1;
    t0 = cyc;
    applyStimulus(1, 4'd9, 4'd3);
    waitDrain(40);
    checkOutput("timeoutRspCycle", 32'(rspCyc - t0), 32'(TIMEOUT + 2));
    divLat = 3;
    applyStimulus(1, 4'd9, 4'd3);
    waitDrain(40);

    // Reset in WAIT discards the request without a response
    divLat = 20;
    t0 = cyc;
    applyStimulus(0, 4'd11, 4'd5);
    while (cyc < t0 + 3) @(negedge clk);
    checkOutput("preResetInWait", 32'(cs), 32'd2);
    rst = 1'b0;
    #1;
    checkOutput("resetMidWait", allOutputs(), 32'd0);
    pend0.delete();
    pend1.delete();
    exp0.delete();
    exp1.delete();
    expGnt.delete();
    inflight.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    divLat = 4;
    applyStimulus(0, 4'd15, 4'd15);
    waitDrain(40);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Shares one `divider` instance between two requesters. It accepts 4-bit divide requests on two independent ports and arbitrates between them round-robin. It sequences the divider's `go`/`done` handshake and returns each result on a common tagged response bus. Divide-by-zero is answered without using the divider, and a watchdog guards against a divider that never asserts `done`.

## Interface
Parameters:
- `WIDTH`, default 4: operand and result width; must match the divider.
- `TIMEOUT`, default 64: maximum number of cycles spent in WAIT before the request is aborted; legal range 2..255.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  request valid from requester 0 / 1. Held high with operands stable until the matching `gnt` pulse.
- `dividend0` / `dividend1`  in  WIDTH  dividend from requester 0 / 1.
- `divisor0` / `divisor1`  in  WIDTH  divisor from requester 0 / 1.
- `gnt0` / `gnt1`  out  1  one-cycle pulse: the request has been accepted and its operands latched.
- `rsp_valid`  out  1  one-cycle pulse: the response fields are valid.
- `rsp_id`  out  1  number of the requester that owns the response.
- `rsp_quotient`  out  WIDTH  quotient.
- `rsp_remainder`  out  WIDTH  remainder.
- `rsp_error`  out  1  set on divide-by-zero, divider error, or timeout.
- `rsp_timeout`  out  1  set only when the watchdog aborted the request.
- `div_go`  out  1  start pulse to the divider.
- `div_dividend` / `div_divisor`  out  WIDTH  operands to the divider, driven from internal latches.
- `div_done`  in  1  divider result-valid signal.
- `div_error`  in  1  divider error flag.
- `div_quotient` / `div_remainder`  in  WIDTH  divider results.
- `busy`  out  1  high in every state except IDLE.
- `cs`  out  2  current state encoding: IDLE=0, ISSUE=1, WAIT=2, RESP=3.

## Operation
- State transitions:
  - IDLE:
    - if no request is pending, stay in IDLE.
    - otherwise, pick a winner, latch its operands and id, and pulse its `gnt` in the next cycle.
    - if the latched divisor is nonzero, go to ISSUE.
    - if the latched divisor is zero, go directly to RESP with error=1, quotient=0, remainder=0, timeout=0.
  - ISSUE: `div_go`=1 for exactly this cycle; `div_done` is ignored; go to WAIT and clear the watchdog counter.
  - WAIT:
    - if `div_done`=1, capture `div_quotient`, `div_remainder` and `div_error` into the response registers (timeout=0) and go to RESP.
    - else if the counter reaches TIMEOUT-1, load quotient=0, remainder=0, error=1, timeout=1 and go to RESP.
    - otherwise increment the counter.
  - RESP: `rsp_valid`=1 for exactly this cycle; go to IDLE.
- Arbitration:
  - a `last_grant` bit holds the id of the most recent winner; its reset value is 1.
  - when only one request is high, that requester wins.
  - when both are high, the requester not equal to `last_grant` wins.
  - `last_grant` updates only when a grant is issued.
- Operand hold: `div_dividend` and `div_divisor` come from the latches and stay constant from ISSUE through RESP.
- Requests are not sampled outside IDLE. A requester that keeps `req` high after its `gnt` is treated as a new request at the next IDLE.
- Response registers hold their values until the next RESP; only `rsp_valid` qualifies them.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, `last_grant`=1, counter=0.
  - every output is 0: `gnt0`, `gnt1`, `rsp_valid`, `rsp_id`, `rsp_quotient`, `rsp_remainder`, `rsp_error`, `rsp_timeout`, `div_go`, `div_dividend`, `div_divisor`, `busy`, `cs`.
- Reset mid-operation discards the in-flight request with no response. The requester must re-request.
- Normal path (all outputs registered):
  - request sampled high at the end of IDLE cycle 0.
  - cycle 1: ISSUE, with `gnt` and `div_go` high.
  - cycles 2..k: WAIT; `div_done` is seen in cycle k.
  - cycle k+1: RESP.
  - cycle k+2: IDLE; a new request can be sampled at the end of this cycle.
- Minimum turnaround is 4 cycles from one grant to the next.
- Divide-by-zero: `gnt` and `rsp_valid` are both high in cycle 1; back in IDLE in cycle 2.
- Timeout: RESP occurs in cycle TIMEOUT+2 when `div_done` never rises.
- `div_done` high together with the final watchdog count: done wins, and the result is captured normally.
- `req0` and `req1` rising in the same cycle: arbitration decides. The loser keeps `req` high and is granted at the next IDLE.

## Test plan
- Single request: `req0`, 13/4, divider done 5 cycles after `go` -> `gnt0` in cycle 1, `div_go` in cycle 1, `rsp_valid` in cycle 7 with id=0, q=3, r=1, error=0.
- Tie after reset: `req0` and `req1` both held, 9/2 and 14/3 -> first grant to 0; then `gnt1` and rsp id=1, q=4, r=2; at no time are both `gnt`s high.
- Round-robin fairness: both requests held for 6 transactions -> grant order 0,1,0,1,0,1.
- Divide-by-zero: `req1`, 7/0 -> `gnt1` and `rsp_valid` in cycle 1, error=1, q=0, r=0, `div_go` never asserted.
- Timeout: TIMEOUT=8, `div_done` tied low -> rsp error=1, timeout=1 in cycle 10; next request is then served normally.
- Reset mid-WAIT: `rst` low in cycle 3 -> all outputs 0 immediately, no `rsp_valid`; after release, `req0` 15/15 returns q=1, r=0.
